draw_manager: RTL and testbench
===============================

Name: draw_manager

Overview:
- Downstream consumer of every draw source on the shared draw-manager bus, including the starfield source.
- Each frame it clears the back framebuffer, then grants sources one at a time in ascending SOURCE_ID order (back to front). It collects their pixel writes and commits them to a double-buffered framebuffer write port.
- Banks swap on the first frame_start after a frame completes.

Parameters:
- SOURCES_COUNT, 4, number of sources (IDs 0..SOURCES_COUNT-1); must be < 2^SOURCE_SEL_ADDRW.
- BG_COLOR, COLOR_DEPTH'(0), colour written during the clear sweep.
- CLEAR_EN, 1, 0 skips the clear sweep.
- AWAIT_TIMEOUT, 1023, cycles to wait for write_active before skipping a source.
- DRAW_WIDTH / DRAW_HEIGHT / COLOR_DEPTH / SOURCE_SEL_ADDRW, package values, geometry and widths.

Ports:
- clk  in  1  clock.
- resetN  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at display vsync.
- write_source_sel  out  SOURCE_SEL_ADDRW  granted source; all-ones = none.
- write_awaited  out  1  manager ready for the granted source.
- write_active  in  1  source is presenting pixels.
- write_color_data  in  COLOR_DEPTH  pixel colour.
- write_transparent  in  1  pixel must not be written.
- write_x_addr  in  DRAW_WIDTH_ADDRW  pixel x.
- write_y_addr  in  DRAW_HEIGHT_ADDRW  pixel y.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  FB_ADDRW  {draw_bank, y*DRAW_WIDTH+x}.
- fb_data  out  COLOR_DEPTH  write data.
- display_bank  out  1  bank read by the display; draw_bank = ~display_bank.
- frame_done  out  1  one-cycle pulse when the last source finishes.
- frame_overrun  out  1  one-cycle pulse on frame_start while the frame is still incomplete.

Behaviour:
- Reset values:
  - write_source_sel = all-ones; write_awaited = 0.
  - fb_we = 0; fb_addr = 0; fb_data = 0.
  - display_bank = 0; frame_done = 0; frame_overrun = 0.
  - State = IDLE.
  - Reset mid-frame aborts immediately; back-bank contents are undefined; no swap occurs.
- States: IDLE, CLEAR, GRANT, AWAIT, DRAIN, NEXT, DONE.
- IDLE: on frame_start go to CLEAR (CLEAR_EN=1) or GRANT. After reset the first frame_start starts drawing without a swap.
- CLEAR:
  - Writes BG_COLOR to every pixel of draw_bank, one per cycle, linear index 0..W*H-1.
  - Goes to GRANT after the last index.
- GRANT:
  - write_source_sel = current src (starts at 0); write_awaited = 1.
  - Goes to AWAIT next cycle.
- AWAIT:
  - Holds write_awaited and counts cycles.
  - write_active=1: drop write_awaited, go to DRAIN, and treat the sample as a pixel.
  - Counter reaches AWAIT_TIMEOUT: go to NEXT with nothing written.
  - Bus inputs are ignored while write_active=0.
- DRAIN:
  - Each cycle with write_active=1, the bus is sampled. When write_transparent=0, x<DRAW_WIDTH and y<DRAW_HEIGHT, the next cycle shows fb_we=1 with fb_addr/fb_data (1-cycle latency). Otherwise fb_we=0.
  - write_active=0 goes to NEXT; this sample is not written.
- NEXT:
  - write_source_sel = all-ones.
  - src == SOURCES_COUNT-1: pulse frame_done, go to DONE. Otherwise src+1, go to GRANT.
- DONE: on frame_start toggle display_bank in the same cycle, then proceed as from IDLE.
- frame_start in any state other than IDLE/DONE: pulse frame_overrun the next cycle. The frame continues; no swap; the pulse is otherwise ignored.
- fb_we is never asserted outside CLEAR and DRAIN-derived writes.
- Each frame starts with src = 0.
- Address arithmetic is unsigned. y*DRAW_WIDTH+x is computed at full width FB_ADDRW-1, with draw_bank as the MSB.

Decomposition:
- frame_manager_pkg holds:
  - DRAW_WIDTH, DRAW_HEIGHT, DRAW_WIDTH_ADDRW, DRAW_HEIGHT_ADDRW, COLOR_DEPTH, SOURCE_SEL_ADDRW.
  - FB_ADDRW = 1 + $clog2(DRAW_WIDTH*DRAW_HEIGHT).
  - SOURCE_SEL_NONE = all-ones.
  - The state enum type.
- One sub-module, fb_clear_sweep: start pulse; emits sequential linear indices with valid; done pulse on the last index.

Test Plan:
All scenarios use W=16, H=8, COLOR_DEPTH=9, SOURCES_COUNT=2, AWAIT_TIMEOUT=20.
1. Reset then frame_start -> 128 consecutive fb_we writes, addr 128..255, data BG_COLOR; then write_source_sel=0 with write_awaited=1.
2. Source 0 presents active for 3 cycles: (2,1,0x1FF,t=0), (3,1,0x0AA,t=1), (20,1,0x011,t=0) -> exactly one write, addr 128+18=146, data 0x1FF. x=20 is dropped; the transparent pixel is dropped.
3. Source 1 never asserts write_active -> after 20 cycles write_source_sel=all-ones, frame_done pulses, no writes.
4. frame_start in DONE -> display_bank 0->1 in the same cycle; the next clear writes addr 0..127.
5. frame_start during CLEAR -> frame_overrun pulses once; the clear continues; display_bank unchanged.
6. resetN=0 mid-DRAIN -> next cycle fb_we=0, write_source_sel=all-ones, write_awaited=0, display_bank=0, state IDLE.

Source files
------------

// File: rtl/frame_manager_pkg.sv
// rtl/frame_manager_pkg.sv - geometry, bus widths, FSM state type and pixel helpers for the draw manager
package frame_manager_pkg;

    localparam int DRAW_WIDTH        = 16;
    localparam int DRAW_HEIGHT       = 8;
    localparam int DRAW_WIDTH_ADDRW  = 5;
    localparam int DRAW_HEIGHT_ADDRW = 4;
    localparam int COLOR_DEPTH       = 9;
    localparam int SOURCE_SEL_ADDRW  = 3;
    localparam int FB_ADDRW          = 1 + $clog2(DRAW_WIDTH * DRAW_HEIGHT);
    localparam int PIX_ADDRW         = FB_ADDRW - 1;

    localparam logic [SOURCE_SEL_ADDRW-1:0] SOURCE_SEL_NONE = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GRANT,
        AWAIT,
        DRAIN,
        NEXT,
        DONE
    } draw_state_e;

    function automatic logic [PIX_ADDRW-1:0] pix_index(
        input logic [DRAW_WIDTH_ADDRW-1:0]  x,
        input logic [DRAW_HEIGHT_ADDRW-1:0] y
    );
        return PIX_ADDRW'(y) * PIX_ADDRW'(DRAW_WIDTH) + PIX_ADDRW'(x);
    endfunction

    function automatic logic pix_on_screen(
        input logic [DRAW_WIDTH_ADDRW-1:0]  x,
        input logic [DRAW_HEIGHT_ADDRW-1:0] y
    );
        return (32'(x) < DRAW_WIDTH) && (32'(y) < DRAW_HEIGHT);
    endfunction

endpackage

// File: rtl/fb_clear_sweep.sv
// rtl/fb_clear_sweep.sv - linear pixel index generator for the background clear pass
module fb_clear_sweep #(
    parameter int NPIX = 128,
    parameter int IDXW = 7
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            start_i,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o,
    output logic            done_o
);

    logic [IDXW-1:0] idx_q;
    logic            active_q;
    logic            last;

    assign last    = (idx_q == IDXW'(NPIX - 1));
    assign idx_o   = idx_q;
    assign valid_o = active_q;
    assign done_o  = active_q && last;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            idx_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            idx_q <= last ? '0 : idx_q + 1'b1;
            if (last) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/draw_manager.sv
// rtl/draw_manager.sv - per-frame clear, back-to-front source arbitration and double-buffered framebuffer writes
module draw_manager
    import frame_manager_pkg::*;
#(
    parameter int                     SOURCES_COUNT = 4,
    parameter logic [COLOR_DEPTH-1:0] BG_COLOR      = COLOR_DEPTH'(0),
    parameter bit                     CLEAR_EN      = 1'b1,
    parameter int                     AWAIT_TIMEOUT = 1023
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_start,
    output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
    output logic                         write_awaited,
    input  logic                         write_active,
    input  logic [COLOR_DEPTH-1:0]       write_color_data,
    input  logic                         write_transparent,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
    output logic                         fb_we,
    output logic [FB_ADDRW-1:0]          fb_addr,
    output logic [COLOR_DEPTH-1:0]       fb_data,
    output logic                         display_bank,
    output logic                         frame_done,
    output logic                         frame_overrun
);

    localparam int CNTW = $clog2(AWAIT_TIMEOUT + 1);

    draw_state_e                 state_q;
    logic [SOURCE_SEL_ADDRW-1:0] src_q;
    logic [SOURCE_SEL_ADDRW-1:0] sel_q;
    logic [CNTW-1:0]             cnt_q;
    logic                        awaited_q;
    logic                        fb_we_q;
    logic [FB_ADDRW-1:0]         fb_addr_q;
    logic [COLOR_DEPTH-1:0]      fb_data_q;
    logic                        display_bank_q;
    logic                        frame_done_q;
    logic                        overrun_q;

    logic                 draw_bank;
    logic                 frame_idle;
    logic                 frame_go;
    logic                 pix_write;
    logic [PIX_ADDRW-1:0] sweep_idx;
    logic                 sweep_valid;
    logic                 sweep_done;

    assign draw_bank  = ~display_bank_q;
    assign frame_idle = (state_q == IDLE) || (state_q == DONE);
    assign frame_go   = frame_start && frame_idle;
    // The first active sample is taken in AWAIT, so both states feed the write port.
    assign pix_write  = ((state_q == AWAIT) || (state_q == DRAIN)) && write_active &&
                        !write_transparent && pix_on_screen(write_x_addr, write_y_addr);

    fb_clear_sweep #(
        .NPIX (DRAW_WIDTH * DRAW_HEIGHT),
        .IDXW (PIX_ADDRW)
    ) u_clear_sweep (
        .clk     (clk),
        .resetN  (resetN),
        .start_i (frame_go && CLEAR_EN),
        .idx_o   (sweep_idx),
        .valid_o (sweep_valid),
        .done_o  (sweep_done)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q        <= IDLE;
            src_q          <= '0;
            sel_q          <= SOURCE_SEL_NONE;
            cnt_q          <= '0;
            awaited_q      <= 1'b0;
            fb_we_q        <= 1'b0;
            fb_addr_q      <= '0;
            fb_data_q      <= '0;
            display_bank_q <= 1'b0;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            fb_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= frame_start && !frame_idle;

            case (state_q)
                IDLE, DONE: begin
                    if (frame_start) begin
                        if (state_q == DONE) begin
                            display_bank_q <= ~display_bank_q;
                        end
                        src_q   <= '0;
                        state_q <= CLEAR_EN ? CLEAR : GRANT;
                    end
                end
                CLEAR: begin
                    if (sweep_valid) begin
                        fb_we_q   <= 1'b1;
                        fb_addr_q <= {draw_bank, sweep_idx};
                        fb_data_q <= BG_COLOR;
                        if (sweep_done) begin
                            state_q <= GRANT;
                        end
                    end
                end
                GRANT: begin
                    sel_q     <= src_q;
                    awaited_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= AWAIT;
                end
                AWAIT: begin
                    if (write_active) begin
                        awaited_q <= 1'b0;
                        state_q   <= DRAIN;
                    end else if (cnt_q == CNTW'(AWAIT_TIMEOUT - 1)) begin
                        awaited_q <= 1'b0;
                        state_q   <= NEXT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!write_active) begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    sel_q <= SOURCE_SEL_NONE;
                    if (src_q == SOURCE_SEL_ADDRW'(SOURCES_COUNT - 1)) begin
                        frame_done_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        src_q   <= src_q + 1'b1;
                        state_q <= GRANT;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (pix_write) begin
                fb_we_q   <= 1'b1;
                fb_addr_q <= {draw_bank, pix_index(write_x_addr, write_y_addr)};
                fb_data_q <= write_color_data;
            end
        end
    end

    assign write_source_sel = sel_q;
    assign write_awaited    = awaited_q;
    assign fb_we            = fb_we_q;
    assign fb_addr          = fb_addr_q;
    assign fb_data          = fb_data_q;
    assign display_bank     = display_bank_q;
    assign frame_done       = frame_done_q;
    assign frame_overrun    = overrun_q;

endmodule

// File: tb/tb_draw_manager.sv
// tb/tb_draw_manager.sv - cycle-timeline model and directed frame scenarios for draw_manager
module tb_draw_manager;
    import frame_manager_pkg::*;

    localparam int              N     = 600;
    localparam int              W     = 16;
    localparam int              H     = 8;
    localparam logic [8:0]      BG    = 9'h0C3;
    localparam logic [2:0]      NONE  = 3'b111;

    typedef struct {
        int         x;
        int         y;
        logic [8:0] c;
        bit         t;
    } pix_t;

    logic                         clk;
    logic                         resetN;
    logic                         frame_start;
    logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
    logic                         write_awaited;
    logic                         write_active;
    logic [COLOR_DEPTH-1:0]       write_color_data;
    logic                         write_transparent;
    logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr;
    logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr;
    logic                         fb_we;
    logic [FB_ADDRW-1:0]          fb_addr;
    logic [COLOR_DEPTH-1:0]       fb_data;
    logic                         display_bank;
    logic                         frame_done;
    logic                         frame_overrun;

    int   cyc;
    int   checks;
    int   errors;
    pix_t cur[$];

    bit         exp_we   [N];
    logic [7:0] exp_addr [N];
    logic [8:0] exp_data [N];
    logic [2:0] exp_sel  [N];
    bit         exp_aw   [N];
    bit         exp_bank [N];
    bit         exp_done [N];
    bit         exp_ovr  [N];

    draw_manager #(
        .SOURCES_COUNT (2),
        .BG_COLOR      (BG),
        .CLEAR_EN      (1'b1),
        .AWAIT_TIMEOUT (20)
    ) dut (
        .clk               (clk),
        .resetN            (resetN),
        .frame_start       (frame_start),
        .write_source_sel  (write_source_sel),
        .write_awaited     (write_awaited),
        .write_active      (write_active),
        .write_color_data  (write_color_data),
        .write_transparent (write_transparent),
        .write_x_addr      (write_x_addr),
        .write_y_addr      (write_y_addr),
        .fb_we             (fb_we),
        .fb_addr           (fb_addr),
        .fb_data           (fb_data),
        .display_bank      (display_bank),
        .frame_done        (frame_done),
        .frame_overrun     (frame_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic pix_t mkpix(input int x, input int y, input logic [8:0] c, input bit t);
        pix_t p;
        p.x = x; p.y = y; p.c = c; p.t = t;
        return p;
    endfunction

    // Everything from cycle c onward returns to the quiet post-reset picture.
    task automatic m_reset(input int c);
        for (int i = c; i < N; i++) begin
            exp_we[i] = 1'b0; exp_addr[i] = '0; exp_data[i] = '0; exp_sel[i] = NONE;
            exp_aw[i] = 1'b0; exp_bank[i] = 1'b0; exp_done[i] = 1'b0; exp_ovr[i] = 1'b0;
        end
    endtask

    task automatic m_frame(input int e0, input bit swap, output int g);
        bit draw;
        if (swap) begin
            for (int i = e0; i < N; i++) exp_bank[i] = !exp_bank[e0 - 1];
        end
        draw = !exp_bank[e0];
        for (int k = 0; k < W * H; k++) begin
            exp_we[e0 + 1 + k]   = 1'b1;
            exp_addr[e0 + 1 + k] = 8'(int'(draw) * W * H + k);
            exp_data[e0 + 1 + k] = BG;
        end
        g = e0 + W * H + 1;
    endtask

    task automatic m_source_pixels(input int g, input int src, input int a, input bit last, output int nxt);
        int  n;
        bit  draw;
        n    = cur.size();
        draw = !exp_bank[g];
        for (int i = g; i <= a; i++) exp_aw[i] = 1'b1;
        for (int i = g; i <= a + n + 1; i++) exp_sel[i] = 3'(src);
        for (int j = 0; j < n; j++) begin
            if (!cur[j].t && cur[j].x < W && cur[j].y < H) begin
                exp_we[a + j + 1]   = 1'b1;
                exp_addr[a + j + 1] = 8'(int'(draw) * W * H + cur[j].y * W + cur[j].x);
                exp_data[a + j + 1] = cur[j].c;
            end
        end
        if (last) exp_done[a + n + 2] = 1'b1;
        nxt = a + n + 3;
    endtask

    task automatic m_source_timeout(input int g, input int src, input bit last, output int nxt);
        for (int i = g; i < g + 20; i++) exp_aw[i] = 1'b1;
        for (int i = g; i <= g + 20; i++) exp_sel[i] = 3'(src);
        if (last) exp_done[g + 21] = 1'b1;
        nxt = g + 22;
    endtask

    task automatic drive_pix(input pix_t p);
        write_x_addr      = DRAW_WIDTH_ADDRW'(p.x);
        write_y_addr      = DRAW_HEIGHT_ADDRW'(p.y);
        write_color_data  = p.c;
        write_transparent = p.t;
        write_active      = 1'b1;
    endtask

    task automatic drive_idle_bus(input int x, input int y, input logic [8:0] c);
        write_x_addr      = DRAW_WIDTH_ADDRW'(x);
        write_y_addr      = DRAW_HEIGHT_ADDRW'(y);
        write_color_data  = c;
        write_transparent = 1'b0;
        write_active      = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            check1("fb_we", cyc, 32'(fb_we), 32'(exp_we[cyc]));
            if (exp_we[cyc]) begin
                check1("fb_addr", cyc, 32'(fb_addr), 32'(exp_addr[cyc]));
                check1("fb_data", cyc, 32'(fb_data), 32'(exp_data[cyc]));
            end
            check1("write_source_sel", cyc, 32'(write_source_sel), 32'(exp_sel[cyc]));
            check1("write_awaited", cyc, 32'(write_awaited), 32'(exp_aw[cyc]));
            check1("display_bank", cyc, 32'(display_bank), 32'(exp_bank[cyc]));
            check1("frame_done", cyc, 32'(frame_done), 32'(exp_done[cyc]));
            check1("frame_overrun", cyc, 32'(frame_overrun), 32'(exp_ovr[cyc]));
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g, nxt, nxt2;
        checks = 0;
        errors = 0;
        resetN = 1'b0;
        frame_start = 1'b0;
        drive_idle_bus(0, 0, 9'h000);
        m_reset(0);

        wait_cyc(2);
        check1("reset fb_addr", cyc, 32'(fb_addr), 32'h0);
        check1("reset fb_data", cyc, 32'(fb_data), 32'h0);
        check1("reset sel", cyc, 32'(write_source_sel), 32'h7);
        wait_cyc(3);
        resetN = 1'b1;

        // Frame 1: clear bank 1, source 0 draws three pixels, source 1 times out.
        wait_cyc(5);
        frame_start = 1'b1;
        m_frame(6, 1'b0, g);
        cur.delete();
        cur.push_back(mkpix(2, 1, 9'h1FF, 1'b0));
        cur.push_back(mkpix(3, 1, 9'h0AA, 1'b1));
        cur.push_back(mkpix(20, 1, 9'h011, 1'b0));
        m_source_pixels(g, 0, g + 2, 1'b0, nxt);
        m_source_timeout(nxt, 1, 1'b1, nxt2);
        wait_cyc(6);
        frame_start = 1'b0;
        wait_cyc(7);
        check1("first clear addr", cyc, 32'(fb_addr), 32'd128);
        check1("first clear data", cyc, 32'(fb_data), 32'(BG));
        wait_cyc(134);
        check1("last clear addr", cyc, 32'(fb_addr), 32'd255);
        wait_cyc(135);
        check1("grant src0 sel", cyc, 32'(write_source_sel), 32'h0);
        check1("grant src0 awaited", cyc, 32'(write_awaited), 32'h1);
        drive_idle_bus(4, 2, 9'h0AA);
        for (int j = 0; j < cur.size(); j++) begin
            wait_cyc(137 + j);
            drive_pix(cur[j]);
        end
        wait_cyc(138);
        check1("pixel addr", cyc, 32'(fb_addr), 32'd146);
        check1("pixel data", cyc, 32'(fb_data), 32'h1FF);
        wait_cyc(140);
        drive_idle_bus(1, 1, 9'h1FF);
        wait_cyc(164);
        check1("frame_done literal", cyc, 32'(frame_done), 32'h1);
        check1("sel none after frame", cyc, 32'(write_source_sel), 32'h7);

        // Frame 2: swap from DONE, overrun during clear, reset while draining.
        wait_cyc(170);
        frame_start = 1'b1;
        m_frame(171, 1'b1, g);
        wait_cyc(171);
        frame_start = 1'b0;
        check1("swap bank literal", cyc, 32'(display_bank), 32'h1);
        wait_cyc(172);
        check1("bank0 clear addr", cyc, 32'(fb_addr), 32'h0);
        wait_cyc(200);
        frame_start = 1'b1;
        exp_ovr[201] = 1'b1;
        wait_cyc(201);
        frame_start = 1'b0;
        check1("overrun literal", cyc, 32'(frame_overrun), 32'h1);
        cur.delete();
        cur.push_back(mkpix(15, 7, 9'h0F0, 1'b0));
        cur.push_back(mkpix(16, 0, 9'h123, 1'b0));
        cur.push_back(mkpix(0, 8, 9'h155, 1'b0));
        cur.push_back(mkpix(1, 0, 9'h1AB, 1'b0));
        m_source_pixels(g, 0, g, 1'b0, nxt);
        for (int j = 0; j < cur.size(); j++) begin
            wait_cyc(300 + j);
            drive_pix(cur[j]);
        end
        resetN = 1'b0;
        m_reset(304);
        wait_cyc(301);
        check1("corner pixel addr", cyc, 32'(fb_addr), 32'd127);
        check1("corner pixel data", cyc, 32'(fb_data), 32'h0F0);
        wait_cyc(304);
        check1("mid-drain reset fb_we", cyc, 32'(fb_we), 32'h0);
        check1("mid-drain reset sel", cyc, 32'(write_source_sel), 32'h7);
        check1("mid-drain reset awaited", cyc, 32'(write_awaited), 32'h0);
        check1("mid-drain reset bank", cyc, 32'(display_bank), 32'h0);
        resetN = 1'b1;
        drive_idle_bus(0, 0, 9'h000);

        // Frame 3: from IDLE after reset, no swap, both sources time out.
        wait_cyc(307);
        frame_start = 1'b1;
        m_frame(308, 1'b0, g);
        m_source_timeout(g, 0, 1'b0, nxt);
        m_source_timeout(nxt, 1, 1'b1, nxt2);
        wait_cyc(308);
        frame_start = 1'b0;
        wait_cyc(309);
        check1("post-reset clear addr", cyc, 32'(fb_addr), 32'd128);
        wait_cyc(490);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
